pipe_mux_n: RTL and testbench
=============================

Name: pipe_mux_n

Overview:
- Parametrised N-way, WIDTH-bit select stage with a registered output and valid/ready handshake on both sides.
- Used in the MIPS pipeline wherever a mux result crosses a stage boundary, e.g. forwarding/ALU-operand select, write-back select and PC-source select.
- Adds these features over the plain 2:1 combinational select:
  - arbitrary input count;
  - 2-entry skid buffering for full throughput under back-pressure;
  - flush;
  - deterministic handling of out-of-range selects, which are tagged and counted instead of producing X.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N.
- ERR_VALUE, 0, WIDTH-bit word emitted when sel >= N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  packed inputs; input k is in_data[k*WIDTH +: WIDTH].
- sel  in  SEL_W  input select, sampled with the input beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat; registered.
- flush  in  1  discard all buffered and incoming beats.
- out_data  out  WIDTH  selected word.
- out_err  out  1  set when the current output beat came from an out-of-range sel.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the beat.
- err_count  out  8  saturating count of accepted out-of-range beats.

Behaviour:
- One clock domain. Reset is synchronous and active-high.

Reset:
- Next edge with reset=1 sets out_valid=0, out_data=0, out_err=0, in_ready=1, err_count=0, and empties both buffer entries.
- Reset overrides flush and all handshakes.
- Reset asserted mid-transfer drops every in-flight beat. No partial state survives.

Transfers:
- Accept = in_valid && in_ready && !flush.
- Output transfer = out_valid && out_ready.

Selection:
- If sel < N, the word is in_data[sel*WIDTH +: WIDTH] and the err tag is 0.
- Otherwise (sel >= N), the word is ERR_VALUE and the err tag is 1.
- Selection is evaluated at accept time. Later input changes do not affect a stored beat.

Storage:
- Two entries: main (drives outputs) and skid. Each entry holds data and err.
- An accepted beat goes to main if main is empty or being transferred out this cycle; otherwise it goes to skid.
- When main transfers out and skid is full, skid moves to main on the same edge.
- in_ready (next) = skid empty after this edge.

Ordering, latency and throughput:
- Beats leave in strict acceptance order.
- Latency is 1 cycle: a beat accepted on edge t is on out_data/out_valid after edge t.
- Sustained throughput is 1 beat/cycle while out_ready=1.

Output stability:
- While out_valid=1 and out_ready=0, out_data and out_err hold constant.
- out_valid never drops without a transfer, except on flush or reset.

Full/empty conditions:
- Both entries full: in_ready=0, no accept.
- Both entries empty: out_valid=0. out_data holds its last value and is don't-care.

Simultaneous accept and output transfer with only main full:
- The new beat replaces main. Skid stays empty.

Flush:
- On the edge with flush=1 (and reset=0), both entries are emptied: out_valid=0 and in_ready=1.
- Any beat presented that cycle is discarded and is not counted.
- A downstream transfer in the same cycle still counts as completed downstream.

err_count:
- Increments by 1 on each accepted beat with sel >= N.
- Saturates at 255. Cleared only by reset.

Test Plan:
- Streaming: N=4, WIDTH=32, in_data={40,30,20,10} (input 0=10), sel cycling 0..3, in_valid=1, out_ready=1 -> out_data 10,20,30,40 on consecutive cycles, 1 cycle after each accept; out_err=0; in_ready stays 1.
- Back-pressure: hold out_ready=0 and present beats sel=1 then sel=2 -> first shows 20 and holds; second is stored in skid; in_ready=0 after the second accept. Release out_ready -> 20 then 30, with no gap and no loss.
- Out-of-range select: N=3, SEL_W=2, sel=3, ERR_VALUE=32'hDEADBEEF -> out_data=DEADBEEF, out_err=1, err_count 0->1. Send 300 bad beats -> err_count saturates at 255.
- Flush with both entries full, plus a new beat offered in the same cycle -> next cycle out_valid=0, in_ready=1, err_count unchanged. The following beat sel=0 gives 10 with 1-cycle latency.
- Reset mid-stream with both entries full and reset=1 for one cycle -> after the edge out_valid=0, out_data=0, out_err=0, err_count=0, in_ready=1. No stale beat appears afterwards.
- Select change after accept: accept sel=0, then change sel and in_data while out_ready=0 -> out_data stays 10 until the transfer completes.

Source files
------------

// File: rtl/pipe_mux_n.sv
// N-way WIDTH-bit select stage with a registered output and a 2-entry skid buffer.
// Out-of-range selects emit ERR_VALUE tagged with out_err and are counted in err_count.
module pipe_mux_n #(
  parameter int              WIDTH     = 32,
  parameter int              N         = 4,
  parameter int              SEL_W     = 2,
  parameter logic [WIDTH-1:0] ERR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           err_count
);

  if (N < 2 || N > 16 || (2 ** SEL_W) < N) begin : g_param_check
    $error("pipe_mux_n: illegal N/SEL_W combination");
  end

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;

  logic accept;
  logic xfer;

  // Only legal indices are ever decoded, so sel >= N falls through to ERR_VALUE.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_word = ERR_VALUE;
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign accept = in_valid && in_ready && !flush;
  assign xfer   = main_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      main_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (accept && sel_err && err_count != 8'hFF) begin
        err_count <= 8'(err_count + 8'd1);
      end

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (xfer && skid_valid) begin
        // Skid is full so in_ready is low: no accept can coincide with this move.
        main_data  <= skid_data;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept && (!main_valid || xfer)) begin
        main_valid <= 1'b1;
        main_data  <= sel_word;
        main_err   <= sel_err;
      end else if (accept) begin
        skid_valid <= 1'b1;
      end else if (xfer) begin
        main_valid <= 1'b0;
      end
    end
  end

  // NOTE: skid payload is qualified by skid_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && main_valid && !xfer) begin
      skid_data <= sel_word;
      skid_err  <= sel_err;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_err   = main_err;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Self-checking bench for pipe_mux_n (N=3, ERR_VALUE=DEADBEEF) using a scoreboard queue:
// expected beats are pushed at accept and popped at each downstream transfer.
module tb_pipe_mux_n;

  localparam int          WIDTH = 32;
  localparam int          N     = 3;
  localparam int          SEL_W = 2;
  localparam logic [31:0] ERR_V = 32'hDEADBEEF;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         err_count;

  logic [WIDTH-1:0] words [N];
  logic [WIDTH:0]   sb [$];
  int               ecnt_exp;
  int               vectors;
  int               miscompares;

  assign in_data = {words[2], words[1], words[0]};

  pipe_mux_n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .ERR_VALUE(ERR_V)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] expect_beat(input logic [SEL_W-1:0] s);
    if (int'(s) < N) return {1'b0, words[s]};
    return {1'b1, ERR_V};
  endfunction

  // One clock: drive at the falling edge, update the scoreboard, advance to the next falling edge.
  task automatic cycle(input logic v, input logic [SEL_W-1:0] s, input logic r,
                       input logic f, input logic rst);
    logic [WIDTH:0] exp_b;
    in_valid  = v;
    sel       = s;
    out_ready = r;
    flush     = f;
    reset     = rst;
    if (rst) begin
      sb.delete();
      ecnt_exp = 0;
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got data=%h err=%b, want no beat", out_data, out_err);
        end else begin
          exp_b = sb.pop_front();
          if ({out_err, out_data} !== exp_b) begin
            miscompares++;
            $display("FAIL sb_beat: got err=%b data=%h, want err=%b data=%h",
                     out_err, out_data, exp_b[WIDTH], exp_b[WIDTH-1:0]);
          end
        end
      end
      if (f) begin
        sb.delete();
      end else if (v && in_ready) begin
        exp_b = expect_beat(s);
        sb.push_back(exp_b);
        if (exp_b[WIDTH] && ecnt_exp < 255) ecnt_exp++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({out_valid, out_err, in_ready, out_data, err_count} !== {3'b001, 32'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b err=%b rdy=%b data=%h cnt=%0d, want 0 0 1 0 0",
               out_valid, out_err, in_ready, out_data, err_count);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, SEL_W'(i % N), 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_%0d: got valid=%b rdy=%b err=%b, want 1 1 0",
                 i, out_valid, in_ready, out_err);
      end
    end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd20 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first: got valid=%b data=%0d rdy=%b, want 1 20 1", out_valid, out_data, in_ready);
    end
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 32'd20 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got data=%0d rdy=%b, want 20 0", out_data, in_ready);
    end
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 32'd20 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: got data=%0d valid=%b rdy=%b, want 20 1 0", out_data, out_valid, in_ready);
    end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd30 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%b data=%0d rdy=%b, want 1 30 1", out_valid, out_data, in_ready);
    end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_out_of_range();
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_data !== ERR_V || out_err !== 1'b1 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL oor_first: got data=%h err=%b cnt=%0d, want deadbeef 1 1", out_data, out_err, err_count);
    end
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (err_count !== 8'(ecnt_exp) || ecnt_exp != 255) begin
      miscompares++;
      $display("FAIL oor_saturate: got cnt=%0d, want 255", err_count);
    end
  endtask

  task automatic test_flush();
    // Only main full, out-of-range beat offered with in_ready=1 and a transfer downstream.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'(ecnt_exp)) begin
      miscompares++;
      $display("FAIL flush_main: got valid=%b rdy=%b cnt=%0d, want 0 1 %0d", out_valid, in_ready, err_count, ecnt_exp);
    end
    // Both entries full with a new beat offered.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'(ecnt_exp)) begin
      miscompares++;
      $display("FAIL flush_full: got valid=%b rdy=%b cnt=%0d, want 0 1 %0d", out_valid, in_ready, err_count, ecnt_exp);
    end
    cycle(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'd10) begin
      miscompares++;
      $display("FAIL flush_after: got valid=%b data=%0d, want 1 10", out_valid, out_data);
    end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({out_valid, out_err, in_ready, out_data, err_count} !== {3'b001, 32'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b err=%b rdy=%b data=%h cnt=%0d, want 0 0 1 0 0",
               out_valid, out_err, in_ready, out_data, err_count);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stale_%0d: got valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_sel_change();
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, SEL_W'(2 - i), 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_data !== 32'd10 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sel_hold_%0d: got data=%h valid=%b, want 0000000a 1", i, out_data, out_valid);
      end
    end
    cycle(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    words[0] = 32'd10;
    words[1] = 32'd20;
    words[2] = 32'd30;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ecnt_exp    = 0;
    words[0]    = 32'd10;
    words[1]    = 32'd20;
    words[2]    = 32'd30;
    reset       = 1'b1;
    in_valid    = 1'b0;
    sel         = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);

    test_reset();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
    test_flush();
    test_sel_change();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
